lfsr_checker: RTL

Serial receive-side checker for the 15-bit XNOR pseudo-random sequence that our LFSR generator produces. It self-synchronises to an incoming one-bit-per-valid stream, declares lock after a run of correct predictions, then free-runs a local copy of the sequence. Against that copy it flags bit errors, counts them, and drops lock when the error density gets too high. It sits at the far end of any link or loopback path that carries the generator's stream, for link/BIST checking in the slot-machine datapath.

---
 rtl/lfsr_checker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 15-bit XNOR LFSR stream: self-syncs, locks, flags and counts bit errors.
// Optional error counter is built only when LFSR_CHECKER_ERRCNT_EN is defined.
module lfsr_checker #(
   parameter int LFSR_LENGTH = 15,
   parameter int LOCK_COUNT  = 32,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 bit_in,
   input  logic                 bit_valid,
   input  logic                 count_clear,
   output logic                 locked,
   output logic                 err,
   output logic [CNT_WIDTH-1:0] error_count
);

   localparam int FILL_W  = $clog2(LFSR_LENGTH + 1);
   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int WIN_W   = $clog2(WINDOW + 1);
   localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

   typedef enum logic [1:0] {FILL, HUNT, LOCKED} state_t;

   state_t                 state_reg, state_next;
   logic [LFSR_LENGTH-1:0] sr_reg, sr_next;
   logic [FILL_W-1:0]      fill_cnt_reg, fill_cnt_next;
   logic [MATCH_W-1:0]     match_cnt_reg, match_cnt_next;
   logic [WIN_W-1:0]       win_bit_reg, win_bit_next;
   logic [WERR_W-1:0]      win_err_reg, win_err_next;
   logic                   locked_reg, locked_next;
   logic                   err_reg, err_next;
   logic                   count_err;

   logic                   predict;
   logic                   mismatch;
   logic [LFSR_LENGTH-1:0] sr_self_sync;

   assign predict      = ~(sr_reg[LFSR_LENGTH-1] ^ sr_reg[LFSR_LENGTH-2]);
   assign mismatch     = (bit_in != predict);
   assign sr_self_sync = {sr_reg[LFSR_LENGTH-2:0], bit_in};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= FILL;
         sr_reg        <= '0;
         fill_cnt_reg  <= '0;
         match_cnt_reg <= '0;
         win_bit_reg   <= '0;
         win_err_reg   <= '0;
         locked_reg    <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sr_reg        <= sr_next;
         fill_cnt_reg  <= fill_cnt_next;
         match_cnt_reg <= match_cnt_next;
         win_bit_reg   <= win_bit_next;
         win_err_reg   <= win_err_next;
         locked_reg    <= locked_next;
         err_reg       <= err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      sr_next        = sr_reg;
      fill_cnt_next  = fill_cnt_reg;
      match_cnt_next = match_cnt_reg;
      win_bit_next   = win_bit_reg;
      win_err_next   = win_err_reg;
      err_next       = 1'b0;
      count_err      = 1'b0;

      if (bit_valid) begin
         case (state_reg)
            FILL: begin
               sr_next = sr_self_sync;
               if (fill_cnt_reg == FILL_W'(LFSR_LENGTH - 1)) begin
                  state_next     = HUNT;
                  fill_cnt_next  = '0;
                  match_cnt_next = '0;
               end else begin
                  fill_cnt_next = fill_cnt_reg + FILL_W'(1);
               end
            end
            HUNT: begin
               sr_next = sr_self_sync;
               // All-ones is the XNOR lock-up state; it predicts itself forever, so never trust it.
               if (mismatch || (&sr_self_sync)) begin
                  match_cnt_next = '0;
               end else if (match_cnt_reg == MATCH_W'(LOCK_COUNT - 1)) begin
                  state_next     = LOCKED;
                  match_cnt_next = '0;
                  win_bit_next   = '0;
                  win_err_next   = '0;
               end else begin
                  match_cnt_next = match_cnt_reg + MATCH_W'(1);
               end
            end
            LOCKED: begin
               // Free-run on the prediction so a line error cannot corrupt the reference.
               sr_next = {sr_reg[LFSR_LENGTH-2:0], predict};
               if (mismatch) begin
                  err_next  = 1'b1;
                  count_err = 1'b1;
               end
               if (mismatch && (win_err_reg == WERR_W'(LOSS_THRESH - 1))) begin
                  state_next     = FILL;
                  fill_cnt_next  = '0;
                  match_cnt_next = '0;
                  win_bit_next   = '0;
                  win_err_next   = '0;
               end else if (win_bit_reg == WIN_W'(WINDOW - 1)) begin
                  win_bit_next = '0;
                  win_err_next = '0;
               end else begin
                  win_bit_next = win_bit_reg + WIN_W'(1);
                  if (mismatch) begin
                     win_err_next = win_err_reg + WERR_W'(1);
                  end
               end
            end
            default: begin
               state_next = FILL;
            end
         endcase
      end

      locked_next = (state_next == LOCKED);
   end

   assign locked = locked_reg;
   assign err    = err_reg;

`ifdef LFSR_CHECKER_ERRCNT_EN
   logic [CNT_WIDTH-1:0] error_count_reg;

   // A clear coinciding with a new error leaves that error counted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         error_count_reg <= '0;
      end else if (count_clear) begin
         error_count_reg <= count_err ? CNT_WIDTH'(1) : '0;
      end else if (count_err && !(&error_count_reg)) begin
         error_count_reg <= error_count_reg + CNT_WIDTH'(1);
      end
   end

   assign error_count = error_count_reg;
`else
   logic errcnt_unused;
   assign errcnt_unused = count_clear ^ count_err;
   assign error_count   = '0;
`endif

endmodule
